// File: rtl/led_fade_pwm.sv
// LED fade stage: per-channel PWM brightness that snaps to full when the
// active-low request pattern lights a channel, then decays linearly one step
// per decay tick, leaving a fading tail behind the stepper sweep.
module led_fade_pwm #(
  parameter int unsigned PWM_BITS  = 4,
  parameter int unsigned DECAY_DIV = 1562500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] pattern_n,
  output logic [7:0] LED
);

  localparam logic [PWM_BITS-1:0] MaxVal    = {PWM_BITS{1'b1}};
  // Last PWM count is MAX-1, so the period is MAX clocks and bright = MAX gives 100% duty.
  localparam logic [PWM_BITS-1:0] PwmLast   = PWM_BITS'(2 ** PWM_BITS - 2);
  localparam logic [23:0]         DecayLast = 24'(DECAY_DIV - 1);

  logic [23:0]         decay_cnt_q, decay_cnt_d;
  logic                decay_tick_q, decay_tick_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] bright_q [8];
  logic [PWM_BITS-1:0] bright_d [8];
  logic [7:0]          led_q, led_d;

  // Prescaler and PWM counter next state.
  always_comb begin
    decay_cnt_d  = decay_cnt_q + 24'd1;
    decay_tick_d = 1'b0;
    if (decay_cnt_q == DecayLast) begin
      decay_cnt_d  = 24'd0;
      decay_tick_d = 1'b1;
    end
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    if (pwm_cnt_q == PwmLast) begin
      pwm_cnt_d = '0;
    end
  end

  // Per-channel brightness update (load beats decay, saturate at 0) and PWM compare.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      bright_d[i] = bright_q[i];
      if (!pattern_n[i]) begin
        bright_d[i] = MaxVal;
      end else if (decay_tick_q && (bright_q[i] != '0)) begin
        bright_d[i] = bright_q[i] - PWM_BITS'(1);
      end
      led_d[i] = ~(pwm_cnt_q < bright_q[i]);
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      decay_cnt_q  <= 24'd0;
      decay_tick_q <= 1'b0;
      pwm_cnt_q    <= '0;
      bright_q     <= '{default: '0};
      led_q        <= 8'hFF;
    end else begin
      decay_cnt_q  <= decay_cnt_d;
      decay_tick_q <= decay_tick_d;
      pwm_cnt_q    <= pwm_cnt_d;
      bright_q     <= bright_d;
      led_q        <= led_d;
    end
  end

  assign LED = led_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Self-checking bench for led_fade_pwm with PWM_BITS = 4 (MAX = 15), DECAY_DIV = 4.
module tb_led_fade_pwm;

  localparam int unsigned PB  = 4;
  localparam int unsigned DIV = 4;
  localparam int          MAX = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pattern_n = 8'h00;
  logic [7:0] LED;

  int checks = 0;
  int errors = 0;

  led_fade_pwm #(
    .PWM_BITS (PB),
    .DECAY_DIV(DIV)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .pattern_n(pattern_n),
    .LED      (LED)
  );

  always #5 clock = ~clock;

  // Reference model: k counts non-reset edges since reset. After k edges the
  // prescaler sits at k mod DIV and the PWM counter at k mod MAX; a decay tick
  // is visible to the edge following edge k whenever k is a nonzero multiple of DIV.
  int unsigned k;
  int          m_bright [8];
  logic [7:0]  m_led;
  bit          m_tick;
  int          m_pwm;

  always @(posedge clock) begin
    if (reset) begin
      k = 0;
      for (int i = 0; i < 8; i++) m_bright[i] = 0;
      m_led = 8'hFF;
    end else begin
      m_tick = (k >= 1) && (k % DIV == 0);
      m_pwm  = int'(k % MAX);
      for (int i = 0; i < 8; i++) m_led[i] = !(m_pwm < m_bright[i]);
      for (int i = 0; i < 8; i++) begin
        if (pattern_n[i] == 1'b0) m_bright[i] = MAX;
        else if (m_tick && m_bright[i] > 0) m_bright[i] = m_bright[i] - 1;
      end
      k = k + 1;
    end
  end

  // Stimulus only: hold reset for two cycles with the given pattern, then release.
  task automatic do_reset(input logic [7:0] pat);
    @(negedge clock);
    reset = 1'b1;
    pattern_n = pat;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pattern_n = 8'h00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (LED !== 8'hFF) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: LED=%h expected ff", c, LED);
      end
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (LED !== 8'hFF) begin
      errors++;
      $display("FAIL reset_first_edge: LED=%h expected ff", LED);
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      checks++;
      if (LED !== 8'h00 || LED !== m_led) begin
        errors++;
        $display("FAIL reset_all_on cyc %0d: LED=%h expected 00 (model %h)", c, LED, m_led);
      end
    end
  endtask

  task automatic test_hold();
    int lows;
    do_reset(8'hFE);
    @(negedge clock);
    lows = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (c < MAX && LED[0] == 1'b0) lows++;
      checks++;
      if (LED !== 8'hFE || LED !== m_led || dut.bright_q[0] !== 4'd15) begin
        errors++;
        $display("FAIL hold cyc %0d: LED=%h bright0=%0d expected LED fe bright0 15",
                 c, LED, dut.bright_q[0]);
      end
    end
    checks++;
    if (lows != MAX) begin
      errors++;
      $display("FAIL hold_duty: lows=%0d expected %0d", lows, MAX);
    end
  endtask

  task automatic test_fade();
    do_reset(8'hFE);
    repeat (10) @(negedge clock);
    pattern_n = 8'hFF;
    for (int c = 0; c < 80; c++) begin
      @(negedge clock);
      checks++;
      if (LED !== m_led || dut.bright_q[0] !== 4'(m_bright[0])) begin
        errors++;
        $display("FAIL fade cyc %0d: LED=%h bright0=%0d expected LED %h bright0 %0d",
                 c, LED, dut.bright_q[0], m_led, m_bright[0]);
      end
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      checks++;
      if (LED[0] !== 1'b1 || dut.bright_q[0] !== 4'd0) begin
        errors++;
        $display("FAIL fade_dark cyc %0d: LED0=%b bright0=%0d expected 1 and 0",
                 c, LED[0], dut.bright_q[0]);
      end
    end
  endtask

  task automatic test_load_beats_decay();
    bit found;
    do_reset(8'hFE);
    repeat (5) @(negedge clock);
    pattern_n = 8'hFF;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clock);
      if (m_bright[0] == 5 && k >= 1 && (k % DIV) == 0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL load_setup: bright0=5 with pending tick never reached (bright0 %0d)",
               dut.bright_q[0]);
    end else begin
      pattern_n = 8'hFE;
      @(negedge clock);
      checks++;
      if (dut.bright_q[0] !== 4'd15) begin
        errors++;
        $display("FAIL load_beats_decay: bright0=%0d expected 15", dut.bright_q[0]);
      end
    end
  endtask

  task automatic test_sweep();
    int seq [14];
    int cur;
    int prev;
    for (int s = 0; s < 8; s++) seq[s] = s;
    for (int s = 8; s < 14; s++) seq[s] = 14 - s;
    do_reset(8'hFF);
    prev = -1;
    for (int s = 0; s < 14; s++) begin
      cur = seq[s];
      pattern_n = ~(8'(1) << cur);
      for (int c = 0; c < 8; c++) begin
        @(negedge clock);
        checks++;
        if (LED !== m_led) begin
          errors++;
          $display("FAIL sweep_led step %0d cyc %0d: LED=%h expected %h", s, c, LED, m_led);
        end
      end
      checks++;
      if (dut.bright_q[cur] !== 4'd15) begin
        errors++;
        $display("FAIL sweep_cur step %0d: bright[%0d]=%0d expected 15",
                 s, cur, dut.bright_q[cur]);
      end
      if (prev >= 0) begin
        checks++;
        if (dut.bright_q[prev] !== 4'd13) begin
          errors++;
          $display("FAIL sweep_prev step %0d: bright[%0d]=%0d expected 13",
                   s, prev, dut.bright_q[prev]);
        end
      end
      prev = cur;
    end
  endtask

  task automatic test_reset_midfade();
    bit found;
    do_reset(8'hF7);
    repeat (4) @(negedge clock);
    pattern_n = 8'hFF;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clock);
      if (m_bright[3] == 9) found = 1'b1;
    end
    checks++;
    if (!found || dut.bright_q[3] !== 4'd9) begin
      errors++;
      $display("FAIL midfade_setup: bright3=%0d expected 9", dut.bright_q[3]);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (LED !== 8'hFF || dut.bright_q[3] !== 4'd0 || dut.decay_cnt_q !== 24'd0 ||
        dut.pwm_cnt_q !== 4'd0) begin
      errors++;
      $display("FAIL midfade_reset: LED=%h bright3=%0d decay=%0d pwm=%0d expected ff 0 0 0",
               LED, dut.bright_q[3], dut.decay_cnt_q, dut.pwm_cnt_q);
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] pat;
    do_reset(8'hFF);
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      checks++;
      if (LED !== m_led) begin
        errors++;
        $display("FAIL random_led cyc %0d: LED=%h expected %h", c, LED, m_led);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (dut.bright_q[i] !== 4'(m_bright[i])) begin
          errors++;
          $display("FAIL random_bright cyc %0d ch %0d: bright=%0d expected %0d",
                   c, i, dut.bright_q[i], m_bright[i]);
        end
      end
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) == 0) begin
        pat = 8'hFF;
        for (int i = 0; i < 8; i++) if ($urandom_range(0, 3) == 0) pat[i] = 1'b0;
        pattern_n = pat;
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hold();
    test_fade();
    test_load_beats_decay();
    test_sweep();
    test_reset_midfade();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
